// File: rtl/rx_peak_report_buffer_if.sv
// Report-buffer bus: peak-report write side, ARM read side, and status.
// The block itself connects through the slave modport; whatever drives it
// (peak detector / ARM glue / testbench) uses the master modport.
interface rx_peak_report_buffer_if #(
   parameter int DEPTH  = 8,
   parameter int DROP_W = 8
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic                erx_en;
   logic signed [40:0]  isample_arm;
   logic [3:0]          ireceived_seq;
   logic [15:0]         itime_arm;
   logic                itrigger_arm;
   logic                iarm_rd;
   logic                iclr_ovf;

   logic signed [40:0]  o_peak;
   logic [3:0]          o_seq;
   logic [15:0]         o_time;
   logic                o_valid;
   logic [CW-1:0]       o_count;
   logic                o_overflow;
   logic [DROP_W-1:0]   o_drop_count;

   modport master (
      output erx_en, isample_arm, ireceived_seq, itime_arm, itrigger_arm,
             iarm_rd, iclr_ovf,
      input  o_peak, o_seq, o_time, o_valid, o_count, o_overflow, o_drop_count
   );

   modport slave (
      input  erx_en, isample_arm, ireceived_seq, itime_arm, itrigger_arm,
             iarm_rd, iclr_ovf,
      output o_peak, o_seq, o_time, o_valid, o_count, o_overflow, o_drop_count
   );
endinterface

// File: rtl/rx_peak_report_buffer.sv
// First-word-fall-through FIFO holding peak reports for the ARM.
// Each report is {signed 41-bit peak, 4-bit sequence, 16-bit timestamp}.
// When full, new reports are dropped unless the ARM pops in the same cycle;
// drops set a sticky overflow flag and bump a saturating drop counter.
// Storage contents are never reset; only pointers, occupancy and status are.
module rx_peak_report_buffer #(
   parameter int DEPTH  = 8,
   parameter int DROP_W = 8
) (
   input logic                     crx_clk,
   input logic                     rrx_rst,
   rx_peak_report_buffer_if.slave  bus
);
   localparam int DATA_W = 41;
   localparam int SEQ_W  = 4;
   localparam int TIME_W = 16;
   localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW     = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   // Drop counter increment that sticks at all-ones.
   function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
      return (&v) ? v : v + DROP_W'(1);
   endfunction

   logic signed [DATA_W-1:0] mem_peak [DEPTH];
   logic [SEQ_W-1:0]         mem_seq  [DEPTH];
   logic [TIME_W-1:0]        mem_time [DEPTH];

   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [CW-1:0]     count;
   logic              overflow;
   logic [DROP_W-1:0] drop_count;

   logic empty;
   logic full;
   logic push_req;
   logic pop;
   logic push;
   logic drop;

   assign empty    = (count == '0);
   assign full     = (count == FULL_CNT);
   assign push_req = bus.itrigger_arm & bus.erx_en;
   // A read on an empty FIFO is ignored, even if a write lands this cycle.
   assign pop      = bus.iarm_rd & ~empty;
   // A full FIFO still accepts a write when the head is leaving this cycle.
   assign push     = push_req & (~full | pop);
   assign drop     = push_req & full & ~pop;

   // Report storage: plain write port, no reset on data.
   always_ff @(posedge crx_clk) begin
      if (push) begin
         mem_peak[wr_ptr] <= bus.isample_arm;
         mem_seq[wr_ptr]  <= bus.ireceived_seq;
         mem_time[wr_ptr] <= bus.itime_arm;
      end
   end

   // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge crx_clk) begin
      if (rrx_rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Sticky overflow and drop counter; a drop in the clearing cycle wins.
   always_ff @(posedge crx_clk) begin
      if (rrx_rst) begin
         overflow   <= 1'b0;
         drop_count <= '0;
      end else if (drop) begin
         overflow   <= 1'b1;
         drop_count <= bus.iclr_ovf ? DROP_W'(1) : sat_inc(drop_count);
      end else if (bus.iclr_ovf) begin
         overflow   <= 1'b0;
         drop_count <= '0;
      end
   end

   // Head entry falls through to the outputs; zero when empty.
   assign bus.o_valid      = ~empty;
   assign bus.o_peak       = empty ? '0 : mem_peak[rd_ptr];
   assign bus.o_seq        = empty ? '0 : mem_seq[rd_ptr];
   assign bus.o_time       = empty ? '0 : mem_time[rd_ptr];
   assign bus.o_count      = count;
   assign bus.o_overflow   = overflow;
   assign bus.o_drop_count = drop_count;

endmodule

// File: tb/tb_rx_peak_report_buffer.sv
// Bench for rx_peak_report_buffer: directed vector table, corner-case
// sequences, and random traffic checked against a queue-based model.
module tb_rx_peak_report_buffer;
   localparam int DEPTH  = 8;
   localparam int DROP_W = 8;
   localparam int MAXD   = (1 << DROP_W) - 1;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   rx_peak_report_buffer_if #(.DEPTH(DEPTH), .DROP_W(DROP_W)) bus ();

   rx_peak_report_buffer #(.DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
      .crx_clk (clk),
      .rrx_rst (rst),
      .bus     (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic signed [40:0] pk;
      logic [3:0]         sq;
      logic [15:0]        tm;
   } ent_t;

   ent_t mq[$];
   bit   m_ovf   = 0;
   int   m_drops = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference behaviour: pop if non-empty, then append unless that would exceed DEPTH.
   task automatic model_step(input bit r, input bit e, input bit t, input bit rd,
                             input bit c, input ent_t x);
      bit popped;
      bit dropped;
      if (r) begin
         mq.delete();
         m_ovf   = 0;
         m_drops = 0;
         return;
      end
      popped  = rd && (mq.size() > 0);
      dropped = 0;
      if (popped) void'(mq.pop_front());
      if (t && e) begin
         if (mq.size() >= DEPTH) dropped = 1;
         else mq.push_back(x);
      end
      if (dropped) begin
         m_ovf   = 1;
         m_drops = c ? 1 : ((m_drops < MAXD) ? m_drops + 1 : MAXD);
      end else if (c) begin
         m_ovf   = 0;
         m_drops = 0;
      end
   endtask

   task automatic check_model(input string tag);
      chk({tag, ".valid"}, bus.o_valid, mq.size() > 0);
      chk({tag, ".count"}, bus.o_count, mq.size());
      chk({tag, ".peak"},  bus.o_peak,  (mq.size() > 0) ? mq[0].pk : 0);
      chk({tag, ".seq"},   bus.o_seq,   (mq.size() > 0) ? mq[0].sq : 0);
      chk({tag, ".time"},  bus.o_time,  (mq.size() > 0) ? mq[0].tm : 0);
      chk({tag, ".ovf"},   bus.o_overflow, m_ovf);
      chk({tag, ".drops"}, bus.o_drop_count, m_drops);
   endtask

   // One clock: drive inputs, advance the model at the edge, release strobes after it.
   task automatic cyc(input bit r, input bit e, input bit t, input bit rd, input bit c,
                      input logic signed [40:0] pk, input logic [3:0] sq,
                      input logic [15:0] tm);
      ent_t x;
      x.pk = pk; x.sq = sq; x.tm = tm;
      rst               = r;
      bus.erx_en        = e;
      bus.itrigger_arm  = t;
      bus.iarm_rd       = rd;
      bus.iclr_ovf      = c;
      bus.isample_arm   = pk;
      bus.ireceived_seq = sq;
      bus.itime_arm     = tm;
      @(posedge clk);
      model_step(r, e, t, rd, c, x);
      #1;
      rst              = 0;
      bus.itrigger_arm = 0;
      bus.iarm_rd      = 0;
      bus.iclr_ovf     = 0;
      bus.erx_en       = 1;
   endtask

   task automatic trig(input logic signed [40:0] pk);
      cyc(0, 1, 1, 0, 0, pk, pk[3:0], pk[15:0]);
   endtask

   task automatic pop1();
      cyc(0, 1, 0, 1, 0, 0, 0, 0);
   endtask

   task automatic do_reset();
      cyc(1, 0, 0, 0, 0, 0, 0, 0);
   endtask

   typedef struct {
      bit     r, e, t, rd, c;
      longint pk;
      int     sq, tm;
      int     ev, ec;
      longint ep;
      int     es, et, eo, ed;
   } vec_t;

   vec_t vt[11];

   initial begin
      logic [63:0] rnd;
      bus.erx_en        = 0;
      bus.itrigger_arm  = 0;
      bus.iarm_rd       = 0;
      bus.iclr_ovf      = 0;
      bus.isample_arm   = '0;
      bus.ireceived_seq = '0;
      bus.itime_arm     = '0;

      //        r e t rd c  pk       sq  tm        ev ec ep       es  et        eo ed
      vt[0]  = '{1,0,0,0,0, 0,       0,  0,        0, 0, 0,       0,  0,        0, 0};
      vt[1]  = '{0,1,1,0,0, -123456, 12, 'h1A2B,   1, 1, -123456, 12, 'h1A2B,   0, 0};
      vt[2]  = '{0,1,0,0,0, 0,       0,  0,        1, 1, -123456, 12, 'h1A2B,   0, 0};
      vt[3]  = '{0,1,0,1,0, 0,       0,  0,        0, 0, 0,       0,  0,        0, 0};
      vt[4]  = '{0,1,0,1,0, 0,       0,  0,        0, 0, 0,       0,  0,        0, 0};
      vt[5]  = '{0,0,1,0,0, 77,      9,  'h77,     0, 0, 0,       0,  0,        0, 0};
      vt[6]  = '{0,1,1,1,0, 5,       1,  5,        1, 1, 5,       1,  5,        0, 0};
      vt[7]  = '{0,1,1,0,0, 6,       2,  6,        1, 2, 5,       1,  5,        0, 0};
      vt[8]  = '{0,1,1,1,0, 7,       3,  7,        1, 2, 6,       2,  6,        0, 0};
      vt[9]  = '{0,1,0,0,1, 0,       0,  0,        1, 2, 6,       2,  6,        0, 0};
      vt[10] = '{1,1,1,1,1, 9,       9,  9,        0, 0, 0,       0,  0,        0, 0};

      repeat (2) @(posedge clk);
      #1;

      foreach (vt[i]) begin
         cyc(vt[i].r, vt[i].e, vt[i].t, vt[i].rd, vt[i].c,
             41'(vt[i].pk), 4'(vt[i].sq), 16'(vt[i].tm));
         chk($sformatf("vec%0d.valid", i), bus.o_valid, vt[i].ev);
         chk($sformatf("vec%0d.count", i), bus.o_count, vt[i].ec);
         chk($sformatf("vec%0d.peak", i),  bus.o_peak,  vt[i].ep);
         chk($sformatf("vec%0d.seq", i),   bus.o_seq,   vt[i].es);
         chk($sformatf("vec%0d.time", i),  bus.o_time,  vt[i].et);
         chk($sformatf("vec%0d.ovf", i),   bus.o_overflow, vt[i].eo);
         chk($sformatf("vec%0d.drops", i), bus.o_drop_count, vt[i].ed);
      end

      // Fill past capacity, then drain in order.
      do_reset();
      for (int i = 1; i <= 10; i++) trig(i);
      chk("fill.count", bus.o_count, 8);
      chk("fill.ovf", bus.o_overflow, 1);
      chk("fill.drops", bus.o_drop_count, 2);
      for (int i = 1; i <= 8; i++) begin
         chk("fill.order", bus.o_peak, i);
         pop1();
      end
      chk("fill.empty", bus.o_valid, 0);

      // Full FIFO with simultaneous write and pop.
      do_reset();
      for (int i = 1; i <= 8; i++) trig(100 + i);
      cyc(0, 1, 1, 1, 0, 200, 4'd8, 16'd200);
      chk("fullpop.count", bus.o_count, 8);
      chk("fullpop.drops", bus.o_drop_count, 0);
      chk("fullpop.ovf", bus.o_overflow, 0);
      for (int k = 0; k < 8; k++) begin
         chk("fullpop.order", bus.o_peak, (k < 7) ? 102 + k : 200);
         pop1();
      end
      check_model("fullpop.end");

      // Empty FIFO with simultaneous write and read.
      do_reset();
      cyc(0, 1, 1, 1, 0, -5, 4'd3, 16'hBEEF);
      chk("emptyrd.count", bus.o_count, 1);
      chk("emptyrd.peak", bus.o_peak, -5);
      chk("emptyrd.time", bus.o_time, 'hBEEF);

      // Disabled trigger, saturating drop counter, clear, clear-vs-drop.
      do_reset();
      cyc(0, 0, 1, 0, 0, 42, 4'd1, 16'd1);
      chk("disabled.count", bus.o_count, 0);
      chk("disabled.drops", bus.o_drop_count, 0);
      for (int i = 0; i < 8; i++) trig(i);
      for (int i = 0; i < 300; i++) trig(1000 + i);
      chk("sat.drops", bus.o_drop_count, 255);
      chk("sat.ovf", bus.o_overflow, 1);
      cyc(0, 0, 1, 0, 0, 1, 1, 1);
      chk("sat.disabled_nodrop", bus.o_drop_count, 255);
      cyc(0, 1, 0, 0, 1, 0, 0, 0);
      chk("clr.drops", bus.o_drop_count, 0);
      chk("clr.ovf", bus.o_overflow, 0);
      cyc(0, 1, 1, 0, 1, 9, 4'd9, 16'd9);
      chk("clrdrop.ovf", bus.o_overflow, 1);
      chk("clrdrop.drops", bus.o_drop_count, 1);
      chk("clrdrop.count", bus.o_count, 8);

      // Reset mid-operation discards stored entries.
      do_reset();
      for (int i = 1; i <= 5; i++) trig(i * 11);
      do_reset();
      chk("midrst.count", bus.o_count, 0);
      chk("midrst.valid", bus.o_valid, 0);
      trig(55);
      chk("midrst.first", bus.o_peak, 55);
      pop1();
      chk("midrst.empty", bus.o_valid, 0);

      // Random traffic against the model.
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         bit r, e, t, rd, c;
         rnd = {$urandom(), $urandom()};
         r  = ($urandom_range(0, 399) == 0);
         e  = ($urandom_range(0, 99) < 85);
         t  = ($urandom_range(0, 99) < 60);
         rd = ($urandom_range(0, 99) < 40);
         c  = ($urandom_range(0, 99) < 5);
         cyc(r, e, t, rd, c, rnd[40:0], rnd[44:41], rnd[60:45]);
         check_model("rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
